// File: rtl/seq_pkg.sv
// Shared types and sizing helpers for the datapath sequencer slice.
// State encoding is fixed at 2 bits so the datapath can decode it directly.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_e;

  localparam int unsigned DEF_NUM_IN      = 8;
  localparam int unsigned DEF_COMP_CYCLES = 4;
  localparam int unsigned DEF_TIMEOUT     = 16;

  // Width that can hold 0..n-1; a count of one still needs a single bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// Handshake and datapath-control bundle between the sequencer and its neighbours.
// master: upstream/downstream/datapath side; slave: the sequencer.
interface datapath_sequencer_if
  import seq_pkg::*;
#(
  parameter int unsigned NUM_IN = DEF_NUM_IN
);

  localparam int unsigned ADDR_W = cnt_w(NUM_IN);

  logic              in_valid;
  logic              in_ready;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic              acc_clr;
  logic              comp_en;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              err;

  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  ld_en,
    input  ld_addr,
    input  acc_clr,
    input  comp_en,
    input  out_valid,
    input  busy,
    input  err
  );

  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output ld_en,
    output ld_addr,
    output acc_clr,
    output comp_en,
    output out_valid,
    output busy,
    output err
  );

endinterface

// File: rtl/seq_counter.sv
// Up-counter with synchronous clear (priority over enable) and terminal-count flag.
// tc_c is a decode of the count register, high while the count equals MAX.
module seq_counter #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned MAX   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             tc_c
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign tc_c = (cnt_q == WIDTH'(MAX));

endmodule

// File: rtl/datapath_sequencer.sv
// Sequences an operand-block load, a fixed-length compute burst and a result handshake.
// Optional LOAD idle-gap timeout enabled by defining SEQ_TIMEOUT_EN.
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned NUM_IN      = DEF_NUM_IN,
  parameter int unsigned COMP_CYCLES = DEF_COMP_CYCLES,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  datapath_sequencer_if.slave  bus
);

  localparam int unsigned LD_W = cnt_w(NUM_IN);
  localparam int unsigned CP_W = cnt_w(COMP_CYCLES);

  if (NUM_IN < 2 || NUM_IN > 256 || COMP_CYCLES < 1 || COMP_CYCLES > 256 ||
      TIMEOUT < 2 || TIMEOUT > 1024) begin : g_bad_params
    $error("datapath_sequencer: parameter out of legal range");
  end

  state_e state_q, state_d;

  logic in_ready_q,  in_ready_d;
  logic acc_clr_q,   acc_clr_d;
  logic comp_en_q,   comp_en_d;
  logic out_valid_q, out_valid_d;
  logic busy_q,      busy_d;
  logic err_q,       err_d;

  logic            xfer_c;
  logic            in_load_c;
  logic            in_comp_c;
  logic            ld_tc_c;
  logic            cp_tc_c;
  logic            timeout_c;
  logic [LD_W-1:0] ld_cnt;
  logic [CP_W-1:0] cp_cnt_unused;

  assign xfer_c    = bus.in_valid & in_ready_q;
  assign in_load_c = (state_q == ST_LOAD);
  assign in_comp_c = (state_q == ST_COMPUTE);

  // Load index doubles as the operand buffer write address.
  seq_counter #(
    .WIDTH (LD_W),
    .MAX   (NUM_IN - 1)
  ) u_ld_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((xfer_c & ld_tc_c) | timeout_c),
    .en    (xfer_c),
    .cnt   (ld_cnt),
    .tc_c  (ld_tc_c)
  );

  seq_counter #(
    .WIDTH (CP_W),
    .MAX   (COMP_CYCLES - 1)
  ) u_cp_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (in_comp_c & cp_tc_c),
    .en    (in_comp_c),
    .cnt   (cp_cnt_unused),
    .tc_c  (cp_tc_c)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned GAP_W = cnt_w(TIMEOUT);

  logic [GAP_W-1:0] gap_cnt_unused;
  logic             gap_tc_c;

  // Timeout fires on the idle cycle that brings the gap count up to TIMEOUT.
  assign timeout_c = in_load_c & ~xfer_c & gap_tc_c;

  seq_counter #(
    .WIDTH (GAP_W),
    .MAX   (TIMEOUT - 1)
  ) u_gap_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~in_load_c | xfer_c | timeout_c),
    .en    (1'b1),
    .cnt   (gap_cnt_unused),
    .tc_c  (gap_tc_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  // Next state plus the registered output values for the state being entered.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = 1'b1;
    acc_clr_d   = 1'b0;
    comp_en_d   = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    err_d       = timeout_c;

    case (state_q)
      ST_IDLE: begin
        if (xfer_c) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (xfer_c && ld_tc_c) begin
          state_d = ST_COMPUTE;
        end else if (timeout_c) begin
          state_d = ST_IDLE;
        end
      end
      ST_COMPUTE: begin
        if (cp_tc_c) state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    comp_en_d   = (state_d == ST_COMPUTE);
    acc_clr_d   = (state_d == ST_COMPUTE) && (state_q != ST_COMPUTE);
    out_valid_d = (state_d == ST_OUTPUT);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      acc_clr_q   <= 1'b0;
      comp_en_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      acc_clr_q   <= acc_clr_d;
      comp_en_q   <= comp_en_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.ld_en     = xfer_c;
  assign bus.ld_addr   = ld_cnt;
  assign bus.acc_clr   = acc_clr_q;
  assign bus.comp_en   = comp_en_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 SHALL have parameter NUM_IN, default 8, samples per operand block (legal 2..256).
REQ-002 SHALL have parameter COMP_CYCLES, default 4, compute cycles per block (legal 1..256).
REQ-003 SHALL have parameter TIMEOUT, default 16, idle-gap limit in LOAD (legal 2..1024).
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream sample present.
REQ-007 SHALL have port in_ready  output  1  sequencer accepts a sample this cycle.
REQ-008 SHALL have port ld_en  output  1  datapath writes the sample into its operand buffer.
REQ-009 SHALL have port ld_addr  output  clog2(NUM_IN)  operand buffer write index.
REQ-010 SHALL have port acc_clr  output  1  datapath accumulator clear.
REQ-011 SHALL have port comp_en  output  1  datapath compute step enable.
REQ-012 SHALL have port out_valid  output  1  result available downstream.
REQ-013 SHALL have port out_ready  input  1  downstream takes result.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port err  output  1  one-cycle timeout pulse.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, COMPUTE, OUTPUT, with a load counter ld_cnt and a compute counter cp_cnt.
REQ-017 in_ready SHALL be 1 in IDLE and LOAD and 0 in COMPUTE and OUTPUT; a transfer occurs when in_valid and in_ready are both 1.
REQ-018 ld_en SHALL equal in_valid AND in_ready (combinational); ld_addr SHALL equal ld_cnt.
REQ-019 IDLE: a transfer SHALL write address 0, set ld_cnt=1 and move to LOAD.
REQ-020 LOAD: each transfer SHALL increment ld_cnt; a transfer at ld_cnt==NUM_IN-1 SHALL clear ld_cnt and move to COMPUTE.
REQ-021 LOAD: cycles without in_valid SHALL hold ld_cnt and ld_addr.
REQ-022 COMPUTE: comp_en SHALL be 1 for exactly COMP_CYCLES consecutive cycles, and acc_clr SHALL be 1 only on the first of them (cp_cnt==0).
REQ-023 COMPUTE: at cp_cnt==COMP_CYCLES-1 the FSM SHALL clear cp_cnt and move to OUTPUT.
REQ-024 OUTPUT: out_valid SHALL be 1 and held until out_ready; on out_valid AND out_ready the FSM SHALL move to IDLE.
REQ-025 in_valid during COMPUTE or OUTPUT SHALL be ignored: no ld_en and no state change.
REQ-026 Latency: with back-to-back input starting at cycle t, comp_en SHALL be high in cycles t+NUM_IN .. t+NUM_IN+COMP_CYCLES-1, and out_valid SHALL first rise at t+NUM_IN+COMP_CYCLES.
REQ-027 A new block SHALL be accepted no earlier than the cycle after the out_valid/out_ready handshake (no overlap).

Reset
REQ-028 When rst_n==0 at a rising edge, the FSM SHALL go to IDLE with ld_cnt=0, cp_cnt=0 and the gap counter at 0, from any state, including mid-LOAD and mid-COMPUTE.
REQ-029 During and after reset, outputs SHALL be: in_ready=1, ld_en=in_valid, ld_addr=0, acc_clr=0, comp_en=0, out_valid=0, busy=0, err=0.

Configuration
REQ-030 Macro SEQ_TIMEOUT_EN defined: in LOAD, a gap counter SHALL count consecutive cycles without a transfer.
REQ-031 With SEQ_TIMEOUT_EN, when the gap count reaches TIMEOUT the FSM SHALL return to IDLE, clear ld_cnt and pulse err for one cycle.
REQ-032 With SEQ_TIMEOUT_EN, any transfer SHALL clear the gap counter.
REQ-033 Macro SEQ_TIMEOUT_EN undefined: there SHALL be no gap counter, LOAD SHALL wait indefinitely, and err SHALL be tied 0; the port SHALL remain present.

Structure
REQ-034 Shared package seq_pkg SHALL hold the state encoding (2-bit: IDLE=0, LOAD=1, COMPUTE=2, OUTPUT=3) and the counter-width helper constants.
REQ-035 One sub-module seq_counter (synchronous clear, enable, terminal-count flag) SHALL be instantiated for ld_cnt and cp_cnt, and for the gap counter when present.

Verification (NUM_IN=8, COMP_CYCLES=4, TIMEOUT=16)
REQ-036 8 back-to-back samples from cycle 10, out_ready=1 -> ld_addr 0..7 in cycles 10-17; comp_en in cycles 18-21; acc_clr in cycle 18 only; out_valid in cycle 22; busy low in cycle 23.
REQ-037 in_valid toggling 1,0,1,0 -> ld_addr advances only on valid cycles; COMPUTE entered after the 8th transfer.
REQ-038 out_ready held 0 for 5 cycles in OUTPUT -> out_valid stays 1; in_valid=1 throughout gives ld_en=0; return to IDLE one cycle after out_ready=1.
REQ-039 rst_n=0 for one cycle at comp cycle 2 -> next cycle is IDLE, comp_en=0, ld_addr=0; a subsequent full block completes normally.
REQ-040 SEQ_TIMEOUT_EN defined, 3 samples then 16 idle cycles -> err high for one cycle, busy=0, next sample written at ld_addr 0.
REQ-041 SEQ_TIMEOUT_EN undefined, same stimulus -> err stays 0, FSM stays in LOAD, next sample written at ld_addr 3.
